digest_hex_tx: RTL and testbench

- Formats a 128-bit MD5 digest as printable ASCII hex and feeds it one byte at a time to the UART transmitter (`usart`).
- Sits directly upstream of `usart`: drives its `bytetosend` and `send` inputs and watches its `sent` output.
- Sends the most significant nibble first, then optionally CR LF, so the host terminal gets one digest per line.

---
 rtl/digest_hex_tx.sv | 103 ++++++++++
 tb/tb_digest_hex_tx.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/digest_hex_tx.sv
// digest_hex_tx: prints a 128-bit digest as 32 ASCII hex characters
// (optionally followed by CR LF) through the usart byte interface.
module digest_hex_tx #(
    parameter bit APPEND_CRLF = 1'b1,
    parameter bit UPPERCASE   = 1'b0
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [127:0] digest,
    input  logic         digest_valid,
    output logic         ready,
    output logic         done,
    output logic [7:0]   tx_byte,
    output logic         tx_send,
    input  logic         tx_sent
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] SEND      = 2'd1;
    localparam logic [1:0] WAIT_LOW  = 2'd2;
    localparam logic [1:0] WAIT_HIGH = 2'd3;

    localparam logic [5:0] LAST_IDX = APPEND_CRLF ? 6'd33 : 6'd31;
    localparam logic [7:0] ALPHA_BASE = UPPERCASE ? 8'h37 : 8'h57;

    logic [1:0]   state;
    logic [5:0]   idx;
    logic [127:0] shreg;
    logic [3:0]   nib;
    logic [7:0]   char_c;

    assign nib = shreg[127:124];

    // ready is held low during the done cycle so a request there is ignored
    assign ready = (state == IDLE) && !done;

    // ASCII character for the current byte position
    always_comb begin
        char_c = 8'h00;
        if (idx == 6'd32) begin
            char_c = 8'h0D;
        end else if (idx == 6'd33) begin
            char_c = 8'h0A;
        end else if (nib < 4'd10) begin
            char_c = 8'h30 + {4'h0, nib};
        end else begin
            char_c = ALPHA_BASE + {4'h0, nib};
        end
    end

    // Handshake FSM: one-cycle send pulse, wait for the frame to start
    // (sent low) and finish (sent high) before moving to the next byte
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            idx     <= 6'd0;
            shreg   <= '0;
            tx_byte <= 8'h00;
            tx_send <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (digest_valid && ready) begin
                        shreg <= digest;
                        idx   <= 6'd0;
                        state <= SEND;
                    end
                end
                SEND: begin
                    if (tx_sent) begin
                        tx_send <= 1'b1;
                        tx_byte <= char_c;
                        state   <= WAIT_LOW;
                    end
                end
                WAIT_LOW: begin
                    tx_send <= 1'b0;
                    if (!tx_sent) begin
                        state <= WAIT_HIGH;
                    end
                end
                WAIT_HIGH: begin
                    if (tx_sent) begin
                        if (idx == LAST_IDX) begin
                            done  <= 1'b1;
                            state <= IDLE;
                        end else begin
                            idx <= idx + 6'd1;
                            if (idx < 6'd32) begin
                                shreg <= {shreg[123:0], 4'h0};
                            end
                            state <= SEND;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_digest_hex_tx.sv
// tb_digest_hex_tx: directed bench for digest_hex_tx driving a
// behavioural usart model (4 clocks per bit, 10-bit frames).
module tb_digest_hex_tx;

    logic         clock;
    logic         reset;
    logic [127:0] dig0, dig1;
    logic         val0, val1;
    logic [1:0]   ready_v, done_v, tx_send_v, tx_sent_v, model_sent, hold;
    logic [7:0]   tx_byte_v [2];

    int cmp = 0;
    int mism = 0;
    int pulses [2];
    int dones [2];
    logic [1:0] prev_send;
    logic [1:0] armed;
    logic [7:0] lastb [2];

    localparam logic [127:0] DIG_A = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] DIG_B = 128'hDEADBEEF_00000000_00000000_CAFEF00D;

    assign tx_sent_v = model_sent & ~hold;

    digest_hex_tx #(.APPEND_CRLF(1'b1), .UPPERCASE(1'b0)) u0 (
        .clock(clock), .reset(reset), .digest(dig0), .digest_valid(val0),
        .ready(ready_v[0]), .done(done_v[0]), .tx_byte(tx_byte_v[0]),
        .tx_send(tx_send_v[0]), .tx_sent(tx_sent_v[0])
    );

    digest_hex_tx #(.APPEND_CRLF(1'b0), .UPPERCASE(1'b1)) u1 (
        .clock(clock), .reset(reset), .digest(dig1), .digest_valid(val1),
        .ready(ready_v[1]), .done(done_v[1]), .tx_byte(tx_byte_v[1]),
        .tx_send(tx_send_v[1]), .tx_sent(tx_sent_v[1])
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // usart model: samples bytetosend mid-bit, never latches it
    for (genvar g = 0; g < 2; g++) begin : mdl
        logic       busy = 1'b0;
        logic [1:0] cnt  = 2'd0;
        logic [3:0] bitn = 4'd0;
        logic [7:0] acc  = 8'h00;
        logic [7:0] rx [512];
        int         rxn  = 0;

        assign model_sent[g] = !busy;

        always_ff @(posedge clock) begin
            if (!busy) begin
                if (tx_send_v[g]) begin
                    busy <= 1'b1;
                    cnt  <= 2'd0;
                    bitn <= 4'd0;
                end
            end else begin
                if (cnt == 2'd1 && bitn >= 4'd1 && bitn <= 4'd8)
                    acc[3'(bitn - 4'd1)] <= tx_byte_v[g][3'(bitn - 4'd1)];
                if (cnt == 2'd3) begin
                    cnt <= 2'd0;
                    if (bitn == 4'd9) begin
                        busy <= 1'b0;
                        rx[rxn[8:0]] <= acc;
                        rxn <= rxn + 1;
                    end else begin
                        bitn <= bitn + 4'd1;
                    end
                end else begin
                    cnt <= cnt + 2'd1;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        cmp++;
        assert (obs === exp) else begin
            mism++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // advance to the next falling edge and run the handshake checks
    task automatic tick();
        @(negedge clock);
        if (reset) armed = 2'b00;
        for (int g = 0; g < 2; g++) begin
            if (tx_send_v[g]) begin
                chk("send_while_busy", 64'(tx_sent_v[g]), 64'd1);
                chk("send_twice", 64'(prev_send[g]), 64'd0);
            end else if (armed[g]) begin
                chk("byte_stable", 64'(tx_byte_v[g]), 64'(lastb[g]));
            end
            prev_send[g] = tx_send_v[g];
            if (tx_send_v[g]) begin
                armed[g] = 1'b1;
                lastb[g] = tx_byte_v[g];
                pulses[g]++;
            end
            if (done_v[g]) dones[g]++;
        end
    endtask

    task automatic wait_done(input int g);
        for (int n = 0; n < 3000 && !done_v[g]; n++) tick();
        chk("done_seen", 64'(done_v[g]), 64'd1);
    endtask

    task automatic wait_pulses(input int g, input int target);
        for (int n = 0; n < 3000 && pulses[g] < target; n++) tick();
        chk("pulse_reached", 64'(pulses[g] >= target), 64'd1);
    endtask

    task automatic check_line(input int g, input int base, input string s,
                              input int n);
        logic [7:0] got, exp;
        for (int i = 0; i < n; i++) begin
            got = (g == 0) ? mdl[0].rx[base + i] : mdl[1].rx[base + i];
            if (i < 32) exp = s[i];
            else if (i == 32) exp = 8'h0D;
            else exp = 8'h0A;
            chk($sformatf("byte%0d", i), 64'(got), 64'(exp));
        end
    endtask

    initial begin
        int base, d0, p0, pb;
        reset = 1'b1;
        dig0 = '0; dig1 = '0;
        val0 = 1'b0; val1 = 1'b0;
        hold = 2'b00;
        prev_send = 2'b00;
        armed = 2'b00;
        pulses[0] = 0; pulses[1] = 0;
        dones[0] = 0; dones[1] = 0;
        lastb[0] = 8'h00; lastb[1] = 8'h00;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        chk("rst_ready", 64'(ready_v[0]), 64'd1);
        chk("rst_done", 64'(done_v[0]), 64'd0);
        chk("rst_send", 64'(tx_send_v[0]), 64'd0);
        chk("rst_byte", 64'(tx_byte_v[0]), 64'h00);
        chk("rst_ready1", 64'(ready_v[1]), 64'd1);

        // basic frame with tx_sent held low for 50 cycles first
        hold[0] = 1'b1;
        dig0 = DIG_A; val0 = 1'b1;
        tick();
        val0 = 1'b0;
        chk("ready_drop", 64'(ready_v[0]), 64'd0);
        repeat (50) tick();
        chk("held_no_pulse", 64'(pulses[0]), 64'd0);
        hold[0] = 1'b0;
        tick();
        chk("first_pulse", 64'(tx_send_v[0]), 64'd1);
        wait_done(0);
        chk("rx_at_done", 64'(mdl[0].rxn), 64'd34);
        chk("ready_in_done", 64'(ready_v[0]), 64'd0);
        tick();
        chk("ready_after_done", 64'(ready_v[0]), 64'd1);
        check_line(0, 0, "0123456789abcdeffedcba9876543210", 34);
        repeat (5) tick();
        chk("one_done", 64'(dones[0]), 64'd1);

        // uppercase, no CR LF
        dig1 = DIG_B; val1 = 1'b1;
        tick();
        val1 = 1'b0;
        wait_done(1);
        chk("ready1_in_done", 64'(ready_v[1]), 64'd0);
        tick();
        chk("ready1_after", 64'(ready_v[1]), 64'd1);
        chk("rx1_count", 64'(mdl[1].rxn), 64'd32);
        check_line(1, 0, "DEADBEEF0000000000000000CAFEF00D", 32);
        repeat (100) tick();
        chk("rx1_no_crlf", 64'(mdl[1].rxn), 64'd32);

        // busy rejection
        base = mdl[0].rxn; d0 = dones[0]; p0 = pulses[0];
        dig0 = DIG_A; val0 = 1'b1;
        tick();
        val0 = 1'b0;
        wait_pulses(0, p0 + 10);
        dig0 = {128{1'b1}}; val0 = 1'b1;
        tick();
        val0 = 1'b0; dig0 = '0;
        wait_done(0);
        repeat (5) tick();
        chk("busy_one_done", 64'(dones[0] - d0), 64'd1);
        chk("busy_count", 64'(mdl[0].rxn - base), 64'd34);
        check_line(0, base, "0123456789abcdeffedcba9876543210", 34);

        // reset mid-frame
        p0 = pulses[0];
        dig0 = DIG_A; val0 = 1'b1;
        tick();
        val0 = 1'b0;
        wait_pulses(0, p0 + 5);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        pb = pulses[0];
        repeat (60) tick();
        chk("no_send_after_rst", 64'(pulses[0]), 64'(pb));
        chk("ready_after_rst", 64'(ready_v[0]), 64'd1);
        chk("byte_after_rst", 64'(tx_byte_v[0]), 64'h00);

        // zeros line followed back-to-back by a second line
        base = mdl[0].rxn; d0 = dones[0];
        dig0 = '0; val0 = 1'b1;
        tick();
        val0 = 1'b0;
        wait_done(0);
        dig0 = {128{1'b1}}; val0 = 1'b1;
        tick();
        chk("b2b_ready", 64'(ready_v[0]), 64'd1);
        dig0 = DIG_A; val0 = 1'b1;
        tick();
        val0 = 1'b0;
        chk("b2b_ready_drop", 64'(ready_v[0]), 64'd0);
        chk("b2b_not_yet", 64'(tx_send_v[0]), 64'd0);
        tick();
        chk("b2b_start", 64'(tx_send_v[0]), 64'd1);
        wait_done(0);
        repeat (5) tick();
        chk("b2b_dones", 64'(dones[0] - d0), 64'd2);
        chk("b2b_count", 64'(mdl[0].rxn - base), 64'd68);
        check_line(0, base, "00000000000000000000000000000000", 34);
        check_line(0, base + 34, "0123456789abcdeffedcba9876543210", 34);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mism);
        $finish;
    end

endmodule
